// File: rtl/tri_wave_sequencer_pkg.sv
// Shared types and defaults for the triangular-wave run controller.
package tri_wave_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOPPING
   } state_t;

   localparam int unsigned WIDTH_DEFAULT = 16;
   localparam int unsigned CYC_W_DEFAULT = 16;
   // 1650 Hz waveform from a 50 MHz clock
   localparam int unsigned DEFAULT_MAX   = 15151;

endpackage

// File: rtl/tri_wave_sequencer_if.sv
// Configuration handshake: peak value and burst length offered with valid/ready.
interface tri_wave_sequencer_if
   import tri_wave_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT,
   parameter int unsigned CYC_W = CYC_W_DEFAULT
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_max;
   logic [CYC_W-1:0] cfg_cycles;

   modport master (output cfg_valid, output cfg_max, output cfg_cycles, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_max, input cfg_cycles, output cfg_ready);
endinterface

// File: rtl/tri_wave_sequencer_core.sv
// Up/down counter producing one triangle period of 2*max_val+2 cycles.
module tri_wave_core #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] count,
   output logic             direction,
   output logic             boundary
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count     <= '0;
         direction <= 1'b0;
      end else if (enable) begin
         if (!direction) begin
            if (count < max_val) count <= count + WIDTH'(1);
            else                 direction <= 1'b1;
         end else begin
            if (count != '0) count <= count - WIDTH'(1);
            else             direction <= 1'b0;
         end
      end
   end

   assign boundary = direction && (count == '0);

endmodule

// File: rtl/tri_wave_sequencer.sv
// Run controller: FSM, active/shadow configuration, handshake and period counting.
module tri_wave_sequencer #(
   parameter int unsigned WIDTH       = tri_wave_pkg::WIDTH_DEFAULT,
   parameter int unsigned CYC_W       = tri_wave_pkg::CYC_W_DEFAULT,
   parameter int unsigned DEFAULT_MAX = tri_wave_pkg::DEFAULT_MAX
) (
   input  logic                   clk,
   input  logic                   reset,
   tri_wave_sequencer_if.slave    cfg,
   input  logic                   start,
   input  logic                   stop,
   output logic                   busy,
   output logic [WIDTH-1:0]       count,
   output logic                   direction,
   output logic                   period_done,
   output logic                   burst_done
);
   import tri_wave_pkg::*;

   state_t           state;
   logic [WIDTH-1:0] act_max, sh_max;
   logic [CYC_W-1:0] act_cycles, sh_cycles, period_cnt, period_next;
   logic             accept, boundary, last_period;

   function automatic logic [WIDTH-1:0] floor_max(input logic [WIDTH-1:0] m);
      return (m == '0) ? WIDTH'(1) : m;
   endfunction

   tri_wave_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .reset     (reset),
      .clear     (state == IDLE),
      .enable    (state != IDLE),
      .max_val   (act_max),
      .count     (count),
      .direction (direction),
      .boundary  (boundary)
   );

   assign accept      = cfg.cfg_valid && cfg.cfg_ready;
   assign period_next = period_cnt + CYC_W'(1);
   assign last_period = (act_cycles != '0) && (period_next == act_cycles);
   assign period_done = boundary && (state != IDLE);
   assign burst_done  = period_done && (state == RUN) && last_period;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         cfg.cfg_ready <= 1'b1;
         act_max       <= WIDTH'(DEFAULT_MAX);
         act_cycles    <= '0;
         sh_max        <= '0;
         sh_cycles     <= '0;
         period_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  act_max    <= floor_max(cfg.cfg_max);
                  act_cycles <= cfg.cfg_cycles;
               end
               if (start) begin
                  state      <= RUN;
                  busy       <= 1'b1;
                  period_cnt <= '0;
               end
            end
            RUN, STOPPING: begin
               if (period_done) period_cnt <= period_next;
               // Entering IDLE: a word arriving now or still pending lands in the active set.
               if (period_done && (state == STOPPING || last_period)) begin
                  state         <= IDLE;
                  busy          <= 1'b0;
                  cfg.cfg_ready <= 1'b1;
                  if (accept) begin
                     act_max    <= floor_max(cfg.cfg_max);
                     act_cycles <= cfg.cfg_cycles;
                  end else if (!cfg.cfg_ready) begin
                     act_max    <= sh_max;
                     act_cycles <= sh_cycles;
                  end
               end else begin
                  if (state == RUN && stop) state <= STOPPING;
                  if (accept) begin
                     sh_max        <= floor_max(cfg.cfg_max);
                     sh_cycles     <= cfg.cfg_cycles;
                     cfg.cfg_ready <= 1'b0;
                  end else if (period_done && !cfg.cfg_ready) begin
                     act_max       <= sh_max;
                     act_cycles    <= sh_cycles;
                     cfg.cfg_ready <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tri_wave_sequencer.sv
// Bench for tri_wave_sequencer: per-cycle comparison against a period-level waveform model.
module tb_tri_wave_sequencer;

   localparam int unsigned W  = 16;
   localparam int unsigned C  = 16;
   localparam int unsigned DM = 15151;

   logic          clk = 1'b0;
   logic          reset, start, stop;
   logic          busy, direction, period_done, burst_done;
   logic [W-1:0]  count;

   int errors = 0;
   int checks = 0;

   // expected per-cycle waveform, built one whole period at a time
   logic [15:0] q_cnt[$];
   logic        q_dir[$];
   logic        q_bnd[$];

   tri_wave_sequencer_if #(.WIDTH(W), .CYC_W(C)) cfg_bus ();

   tri_wave_sequencer #(.WIDTH(W), .CYC_W(C), .DEFAULT_MAX(DM)) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg         (cfg_bus),
      .start       (start),
      .stop        (stop),
      .busy        (busy),
      .count       (count),
      .direction   (direction),
      .period_done (period_done),
      .burst_done  (burst_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_period(input int m);
      int mm;
      mm = (m == 0) ? 1 : m;
      for (int p = 0; p < 2 * mm + 2; p++) begin
         q_cnt.push_back(16'(p <= mm ? p : (p == mm + 1 ? mm : 2 * mm + 1 - p)));
         q_dir.push_back(p > mm);
         q_bnd.push_back(p == 2 * mm + 1);
      end
   endtask

   task automatic clear_model();
      q_cnt.delete();
      q_dir.delete();
      q_bnd.delete();
   endtask

   task automatic send_cfg(input int m, input int c);
      cfg_bus.cfg_valid  = 1'b1;
      cfg_bus.cfg_max    = 16'(m);
      cfg_bus.cfg_cycles = 16'(c);
      step();
      cfg_bus.cfg_valid  = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; stop = 1'b0;
      cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_max = '0; cfg_bus.cfg_cycles = '0;
      step(); step();
      reset = 1'b0;
      checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", count); end
      checks++; if (direction !== 1'b0) begin errors++; $display("FAIL reset_dir got %b expected 0", direction); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
      checks++; if (period_done !== 1'b0) begin errors++; $display("FAIL reset_pd got %b expected 0", period_done); end
      checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL reset_bd got %b expected 0", burst_done); end
      checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", cfg_bus.cfg_ready); end
   endtask

   task automatic test_default_run();
      int pd_early, busy_low, plen;
      pd_early = 0; busy_low = 0; plen = 2 * DM + 2;
      pulse_start();
      for (int t = 1; t <= plen; t++) begin
         if (t == 1) begin
            checks++; if (count !== 16'd0) begin errors++; $display("FAIL default_first got %0d expected 0", count); end
         end
         if (t == DM + 1) begin
            checks++; if (count !== 16'(DM)) begin errors++; $display("FAIL default_peak got %0d expected %0d", count, DM); end
         end
         if (t < plen && period_done) pd_early++;
         if (!busy) busy_low++;
         if (t == plen) begin
            checks++; if (period_done !== 1'b1 || count !== 16'd0 || direction !== 1'b1)
               begin errors++; $display("FAIL default_boundary got pd=%b cnt=%0d dir=%b expected pd=1 cnt=0 dir=1", period_done, count, direction); end
         end
         else step();
      end
      checks++; if (pd_early != 0) begin errors++; $display("FAIL default_pd_early got %0d expected 0", pd_early); end
      checks++; if (busy_low != 0) begin errors++; $display("FAIL default_busy got %0d low cycles expected 0", busy_low); end
      reset = 1'b1; step(); reset = 1'b0;
   endtask

   task automatic test_burst(input int m, input int c, input string name);
      logic [20:0] obs, expv;
      int n;
      logic e_bnd;
      send_cfg(m, c);
      checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL %s idle_ready got %b expected 1", name, cfg_bus.cfg_ready); end
      clear_model();
      for (int k = 0; k < c; k++) push_period(m);
      n = q_cnt.size();
      pulse_start();
      for (int i = 0; i < n; i++) begin
         e_bnd = q_bnd.pop_front();
         expv  = {1'b1, 1'b1, e_bnd && (i == n - 1), e_bnd, q_dir.pop_front(), q_cnt.pop_front()};
         obs   = {cfg_bus.cfg_ready, busy, burst_done, period_done, direction, count};
         checks++; if (obs !== expv) begin errors++; $display("FAIL %s cycle %0d got %h expected %h", name, i, obs, expv); end
         step();
      end
      obs = {cfg_bus.cfg_ready, busy, burst_done, period_done, direction, count};
      checks++; if (obs !== 21'h100000) begin errors++; $display("FAIL %s idle_after got %h expected %h", name, obs, 21'h100000); end
   endtask

   task automatic test_min_max();
      test_burst(0, 3, "min_max");
   endtask

   task automatic test_reconfig();
      logic [20:0] obs, expv;
      int n, waited;
      send_cfg(3, 0);
      clear_model();
      push_period(3); push_period(5); push_period(5);
      n = q_cnt.size();
      pulse_start();
      for (int i = 0; i < n; i++) begin
         expv = {!(i >= 3 && i <= 7), 1'b1, 1'b0, q_bnd.pop_front(), q_dir.pop_front(), q_cnt.pop_front()};
         obs  = {cfg_bus.cfg_ready, busy, burst_done, period_done, direction, count};
         checks++; if (obs !== expv) begin errors++; $display("FAIL reconfig cycle %0d got %h expected %h", i, obs, expv); end
         cfg_bus.cfg_valid = (i >= 2 && i < 7);
         cfg_bus.cfg_max   = (i == 2) ? 16'd5 : 16'd7;
         step();
      end
      cfg_bus.cfg_valid = 1'b0;
      stop = 1'b1; step(); stop = 1'b0;
      waited = 0;
      while (busy && waited < 40) begin step(); waited++; end
      checks++; if (busy !== 1'b0 || count !== 16'd0) begin errors++; $display("FAIL reconfig_stop got busy=%b cnt=%0d expected busy=0 cnt=0", busy, count); end
   endtask

   task automatic test_stop();
      logic [20:0] obs, expv;
      int m, n;
      m = 4 + int'($urandom_range(0, 4));
      send_cfg(m, 0);
      clear_model();
      push_period(m);
      n = q_cnt.size();
      pulse_start();
      for (int i = 0; i < n; i++) begin
         expv = {1'b1, 1'b1, 1'b0, q_bnd.pop_front(), q_dir.pop_front(), q_cnt.pop_front()};
         obs  = {cfg_bus.cfg_ready, busy, burst_done, period_done, direction, count};
         checks++; if (obs !== expv) begin errors++; $display("FAIL stop cycle %0d got %h expected %h", i, obs, expv); end
         stop = (i == 1);
         step();
      end
      stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         obs = {cfg_bus.cfg_ready, busy, burst_done, period_done, direction, count};
         checks++; if (obs !== 21'h100000) begin errors++; $display("FAIL stop_idle %0d got %h expected %h", i, obs, 21'h100000); end
         step();
      end
   endtask

   task automatic test_start_stop_same();
      logic [20:0] obs, expv;
      int n;
      send_cfg(5, 0);
      clear_model();
      push_period(5); push_period(5);
      n = q_cnt.size();
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      for (int i = 0; i < n; i++) begin
         expv = {1'b1, 1'b1, 1'b0, q_bnd.pop_front(), q_dir.pop_front(), q_cnt.pop_front()};
         obs  = {cfg_bus.cfg_ready, busy, burst_done, period_done, direction, count};
         checks++; if (obs !== expv) begin errors++; $display("FAIL start_stop cycle %0d got %h expected %h", i, obs, expv); end
         step();
      end
      reset = 1'b1; step(); reset = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [20:0] obs;
      send_cfg(6, 0);
      pulse_start();
      step(); step(); step();
      checks++; if (count !== 16'd3) begin errors++; $display("FAIL reset_mid_pre got %0d expected 3", count); end
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         obs = {cfg_bus.cfg_ready, busy, burst_done, period_done, direction, count};
         checks++; if (obs !== 21'h100000) begin errors++; $display("FAIL reset_mid %0d got %h expected %h", i, obs, 21'h100000); end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_default_run();
      test_burst(3, 2, "burst_3x2");
      for (int k = 0; k < 3; k++)
         test_burst(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)), "burst_rand");
      test_min_max();
      test_reconfig();
      test_stop();
      test_start_stop_same();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
